// File: rtl/fb_write_sched.sv
// fb_write_sched: arbitrates the framebuffer write port between the UART pixel
// stream and a whole-bank fill engine, and owns double-buffer bank swapping.
module fb_write_sched #(
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        data_in,
  input  logic              data_valid,
  input  logic              image_start,
  input  logic              image_end,
  input  logic              clear_req,
  input  logic [1:0]        clear_color,
  input  logic              lcd_vsync,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        wr_data,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              clear_busy,
  output logic              image_complete,
  output logic              overflow,
  output logic [7:0]        frame_count
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RECV, DRAIN, WAIT_VS} state_t;

  state_t            state;
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PW:0]       wptr;
  logic [PW:0]       rptr;
  logic [PW:0]       fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic [7:0]        fifo_head;
  logic [7:0]        shift_byte;
  logic [2:0]        pix_left;
  logic [ADDR_W-1:0] pix_addr;
  logic              addr_sat;
  logic [ADDR_W:0]   fill_next;
  logic [1:0]        fill_color;
  logic              vs_meta;
  logic              vs_sync;
  logic              vs_prev;

  logic              push;
  logic              fill_accept;
  logic              fill_writing;
  logic              unpack_load;
  logic              unpack_step;
  logic [1:0]        pix_sel;
  logic              swap_evt;
  logic              do_swap;

  assign fifo_count   = wptr - rptr;
  assign fifo_empty   = (wptr == rptr);
  assign fifo_full    = (fifo_count == (PW+1)'(FIFO_DEPTH));
  assign fifo_head    = fifo_mem[rptr[PW-1:0]];
  assign push         = (state == RECV) && data_valid && !image_start;

  // The fill owns the port from the accepting edge until its last address is written.
  assign fill_accept  = clear_req && !clear_busy;
  assign fill_writing = fill_accept || (clear_busy && !fill_next[ADDR_W]);
  assign unpack_load  = !fill_writing && !image_start && (pix_left == 3'd0) && !fifo_empty;
  assign unpack_step  = !fill_writing && !image_start && (pix_left != 3'd0);
  assign pix_sel      = unpack_load ? fifo_head[7:6] : shift_byte[7:6];

  assign swap_evt     = vs_prev && !vs_sync;
  assign do_swap      = (state == WAIT_VS) && !image_start && swap_evt &&
                        !clear_busy && !fill_accept;
  assign rd_bank      = ~wr_bank;

  always_ff @(posedge clk) begin
    if (reset_n && push && !fifo_full)
      fifo_mem[wptr[PW-1:0]] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      wptr           <= '0;
      rptr           <= '0;
      shift_byte     <= '0;
      pix_left       <= '0;
      pix_addr       <= '0;
      addr_sat       <= 1'b0;
      fill_next      <= '0;
      fill_color     <= '0;
      vs_meta        <= 1'b1;
      vs_sync        <= 1'b1;
      vs_prev        <= 1'b1;
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      wr_bank        <= 1'b1;
      clear_busy     <= 1'b0;
      image_complete <= 1'b0;
      overflow       <= 1'b0;
      frame_count    <= '0;
    end else begin
      wr_en          <= 1'b0;
      image_complete <= 1'b0;
      vs_meta        <= lcd_vsync;
      vs_sync        <= vs_meta;
      vs_prev        <= vs_sync;

      if (fill_accept) begin
        clear_busy <= 1'b1;
        fill_color <= clear_color;
        fill_next  <= (ADDR_W+1)'(1);
        wr_en      <= 1'b1;
        wr_addr    <= '0;
        wr_data    <= clear_color;
      end else if (clear_busy) begin
        if (fill_next[ADDR_W]) begin
          clear_busy <= 1'b0;
        end else begin
          wr_en     <= 1'b1;
          wr_addr   <= fill_next[ADDR_W-1:0];
          wr_data   <= fill_color;
          fill_next <= fill_next + 1'b1;
        end
      end

      // A new image start flushes all stream state regardless of the current state.
      if (image_start) begin
        wptr     <= '0;
        rptr     <= '0;
        pix_left <= '0;
        pix_addr <= '0;
        addr_sat <= 1'b0;
        overflow <= 1'b0;
        state    <= RECV;
      end else begin
        if (push) begin
          if (fifo_full) overflow <= 1'b1;
          else           wptr     <= wptr + 1'b1;
        end

        if (unpack_load || unpack_step) begin
          if (unpack_load) begin
            rptr       <= rptr + 1'b1;
            shift_byte <= {fifo_head[5:0], 2'b00};
            pix_left   <= 3'd3;
          end else begin
            shift_byte <= {shift_byte[5:0], 2'b00};
            pix_left   <= pix_left - 3'd1;
          end
          if (addr_sat) begin
            overflow <= 1'b1;
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= pix_addr;
            wr_data <= pix_sel;
            if (&pix_addr) addr_sat <= 1'b1;
            else           pix_addr <= pix_addr + 1'b1;
          end
        end

        case (state)
          RECV:  if (image_end) state <= DRAIN;
          DRAIN: if (fifo_empty && (pix_left == 3'd0) && !clear_busy) state <= WAIT_VS;
          WAIT_VS: begin
            if (do_swap) begin
              wr_bank        <= ~wr_bank;
              image_complete <= 1'b1;
              frame_count    <= frame_count + 8'd1;
              state          <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fb_write_sched.sv
// tb_fb_write_sched: randomized scoreboard bench for fb_write_sched using a
// reduced image size so whole-image and whole-fill scenarios stay short.
module tb_fb_write_sched;

  localparam int ADDR_W = 8;
  localparam int NPIX   = 1 << ADDR_W;
  localparam int NBYTES = NPIX / 4;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [7:0]        data_in;
  logic              data_valid;
  logic              image_start;
  logic              image_end;
  logic              clear_req;
  logic [1:0]        clear_color;
  logic              lcd_vsync;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        wr_data;
  logic              wr_bank;
  logic              rd_bank;
  logic              clear_busy;
  logic              image_complete;
  logic              overflow;
  logic [7:0]        frame_count;

  fb_write_sched #(.ADDR_W(ADDR_W), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid),
    .image_start(image_start), .image_end(image_end), .clear_req(clear_req),
    .clear_color(clear_color), .lcd_vsync(lcd_vsync), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_bank(wr_bank), .rd_bank(rd_bank),
    .clear_busy(clear_busy), .image_complete(image_complete), .overflow(overflow),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  wr_t sq[$];
  wr_t fq[$];
  int  model_addr = 0;
  int  exp_ovf = 0;
  int  exp_bank = 1;
  int  exp_frames = 0;
  int  swaps = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: writes during a fill belong to the fill, all others to the stream.
  always @(negedge clk) begin
    if (reset_n) begin
      if (image_complete) swaps++;
      if (wr_en) begin
        wr_t e;
        checkOutput("wr_bank_during_write", wr_bank, exp_bank);
        if (clear_busy) begin
          if (fq.size() == 0) checkOutput("unexpected_fill_write", 1, 0);
          else begin
            e = fq.pop_front();
            checkOutput("fill_addr", wr_addr, e.addr);
            checkOutput("fill_data", wr_data, e.data);
          end
        end else begin
          if (sq.size() == 0) checkOutput("unexpected_stream_write", 1, 0);
          else begin
            e = sq.pop_front();
            checkOutput("stream_addr", wr_addr, e.addr);
            checkOutput("stream_data", wr_data, e.data);
          end
        end
      end
    end
  end

  // Byte pushed by the stream; keep=0 marks a byte the FIFO is expected to drop.
  task automatic applyStimulus(input logic [7:0] b, input bit keep);
    if (keep) begin
      for (int k = 0; k < 4; k++) begin
        if (model_addr < NPIX) begin
          sq.push_back('{model_addr, (int'(b) >> (6 - 2*k)) & 3});
          model_addr++;
        end else begin
          exp_ovf = 1;
        end
      end
    end else begin
      exp_ovf = 1;
    end
    data_in    = b;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic sendBytes(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(8'($urandom), 1'b1);
      repeat ($urandom_range(3, 6)) tick();
    end
  endtask

  task automatic pulseImageStart();
    image_start = 1'b1;
    tick();
    image_start = 1'b0;
    model_addr = 0;
    exp_ovf    = 0;
  endtask

  task automatic pulseImageEnd();
    image_end = 1'b1;
    tick();
    image_end = 1'b0;
  endtask

  task automatic requestClear(input logic [1:0] c);
    for (int a = 0; a < NPIX; a++) fq.push_back('{a, int'(c)});
    clear_color = c;
    clear_req   = 1'b1;
    tick();
    clear_req   = 1'b0;
    @(negedge clk);
    checkOutput("clear_busy_after_accept", clear_busy, 1);
    tick();
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while ((sq.size() != 0 || fq.size() != 0 || clear_busy) && n < 3000) begin
      tick();
      n++;
    end
    checkOutput(name, (sq.size() != 0 || fq.size() != 0) ? 1 : 0, 0);
    repeat (3) tick();
  endtask

  task automatic vsyncPulse();
    lcd_vsync = 1'b0;
    repeat (3) tick();
    lcd_vsync = 1'b1;
  endtask

  task automatic expectSwap(input string name);
    int s0 = swaps;
    int n  = 0;
    vsyncPulse();
    while (swaps == s0 && n < 20) begin
      tick();
      n++;
    end
    exp_bank   = 1 - exp_bank;
    exp_frames = exp_frames + 1;
    repeat (3) tick();
    @(negedge clk);
    checkOutput({name, "_swap_pulses"}, swaps - s0, 1);
    checkOutput({name, "_wr_bank"}, wr_bank, exp_bank);
    checkOutput({name, "_rd_bank"}, rd_bank, 1 - exp_bank);
    checkOutput({name, "_frame_count"}, frame_count, exp_frames & 255);
  endtask

  task automatic expectNoSwap(input string name);
    int s0 = swaps;
    vsyncPulse();
    repeat (20) tick();
    @(negedge clk);
    checkOutput({name, "_swap_pulses"}, swaps - s0, 0);
    checkOutput({name, "_rd_bank"}, rd_bank, 1 - exp_bank);
    checkOutput({name, "_frame_count"}, frame_count, exp_frames & 255);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0; data_in = '0; data_valid = 1'b0; image_start = 1'b0;
    image_end = 1'b0; clear_req = 1'b0; clear_color = '0; lcd_vsync = 1'b1;
    repeat (4) tick();
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_wr_en", wr_en, 0);
    checkOutput("rst_wr_addr", wr_addr, 0);
    checkOutput("rst_wr_data", wr_data, 0);
    checkOutput("rst_wr_bank", wr_bank, 1);
    checkOutput("rst_rd_bank", rd_bank, 0);
    checkOutput("rst_clear_busy", clear_busy, 0);
    checkOutput("rst_image_complete", image_complete, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_frame_count", frame_count, 0);
    tick();

    // First byte: two-cycle latency to the first write.
    pulseImageStart();
    tick();
    applyStimulus(8'hE4, 1'b1);
    @(negedge clk);
    checkOutput("latency_cycle1_wr_en", wr_en, 0);
    @(negedge clk);
    checkOutput("latency_cycle2_wr_en", wr_en, 1);
    checkOutput("latency_cycle2_addr", wr_addr, 0);
    checkOutput("latency_cycle2_data", wr_data, 3);
    tick();

    // Rest of a full image, then the swap.
    sendBytes(NBYTES - 1);
    pulseImageEnd();
    waitDrain("full_image_drain");
    @(negedge clk);
    checkOutput("full_image_overflow", overflow, 0);
    tick();
    expectSwap("full_image");

    // Fill mid-stream; bytes arriving during the fill resume at address 40.
    pulseImageStart();
    sendBytes(10);
    waitDrain("pre_fill_drain");
    requestClear(2'd2);
    sendBytes(8);
    waitDrain("fill_resume_drain");
    @(negedge clk);
    checkOutput("fill_resume_overflow", overflow, 0);
    tick();

    // Nine bytes during a fill with the unpacker stalled: the ninth is dropped.
    pulseImageStart();
    requestClear(2'd1);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(8'($urandom), i < 8);
      repeat ($urandom_range(1, 4)) tick();
    end
    waitDrain("fifo_drop_drain");
    @(negedge clk);
    checkOutput("fifo_drop_overflow", overflow, exp_ovf);
    tick();
    pulseImageStart();
    @(negedge clk);
    checkOutput("overflow_cleared_by_start", overflow, 0);
    tick();

    // One byte past the end of the image saturates without wrapping.
    sendBytes(NBYTES + 1);
    waitDrain("saturate_drain");
    @(negedge clk);
    checkOutput("saturate_overflow", overflow, exp_ovf);
    tick();
    pulseImageEnd();
    repeat (5) tick();
    expectSwap("saturate_image");

    // Abort from WAIT_VS: no swap, new stream restarts at address 0.
    pulseImageStart();
    sendBytes(3);
    pulseImageEnd();
    waitDrain("abort_pre_drain");
    repeat (5) tick();
    pulseImageStart();
    expectNoSwap("abort_wait_vs");
    sendBytes(2);
    waitDrain("abort_restart_drain");

    // A fill started in WAIT_VS holds off the swap until it completes.
    pulseImageEnd();
    repeat (5) tick();
    requestClear(2'd0);
    expectNoSwap("fill_blocks_swap");
    waitDrain("fill_blocks_drain");
    expectSwap("after_fill");

    checkOutput("stream_queue_empty", sq.size(), 0);
    checkOutput("fill_queue_empty", fq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
